// File: rtl/fmul_exec_pipe.sv
// Execution wrapper for the FP multiply unit: operand stage, fixed-latency
// product delay line, in-order result FIFO and credit-gated CDB request.
module fmul_exec_pipe #(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned LAT   = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [31:0]      issue_a,
    input  logic [31:0]      issue_b,
    output logic [31:0]      mul_x1,
    output logic [31:0]      mul_x2,
    input  logic [31:0]      mul_x3,
    output logic             cdb_req,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_value,
    output logic [2:0]       cdb_flags,
    input  logic             cdb_grant,
    output logic             busy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             accept;
    logic             pop;
    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;

    logic             wr_valid;
    logic [TAG_W-1:0] wr_tag;
    logic [31:0]      wr_value;
    logic [2:0]       wr_flags;

    logic [TAG_W-1:0] mem_tag   [DEPTH];
    logic [31:0]      mem_value [DEPTH];
    logic [2:0]       mem_flags [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    fcount;
    logic [CW-1:0]    fcount_nxt;
    logic [CW-1:0]    fremain;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;

    logic             head_req_nxt;
    logic [TAG_W-1:0] head_tag_nxt;
    logic [31:0]      head_value_nxt;
    logic [2:0]       head_flags_nxt;

    assign accept = issue_valid && issue_ready;
    assign pop    = cdb_grant && cdb_req;

    // Product delay line: LAT-2 stages, or a direct FIFO write when LAT is 2.
    if (LAT > 2) begin : g_dline
        localparam int unsigned DL = LAT - 2;
        logic             dl_valid [DL];
        logic [TAG_W-1:0] dl_tag   [DL];
        logic [31:0]      dl_value [DL];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(DL); i++) begin
                    dl_valid[i] <= 1'b0;
                    dl_tag[i]   <= '0;
                    dl_value[i] <= '0;
                end
            end else begin
                dl_valid[0] <= s1_valid;
                dl_tag[0]   <= s1_tag;
                dl_value[0] <= mul_x3;
                for (int i = 1; i < int'(DL); i++) begin
                    dl_valid[i] <= dl_valid[i-1];
                    dl_tag[i]   <= dl_tag[i-1];
                    dl_value[i] <= dl_value[i-1];
                end
            end
        end

        assign wr_valid = dl_valid[DL-1];
        assign wr_tag   = dl_tag[DL-1];
        assign wr_value = dl_value[DL-1];
    end else begin : g_direct
        assign wr_valid = s1_valid;
        assign wr_tag   = s1_tag;
        assign wr_value = mul_x3;
    end

    // {nan, inf, zero}; sign ignored, denormals unflagged.
    always_comb begin
        wr_flags = 3'b000;
        if (wr_value[30:23] == 8'hFF) begin
            wr_flags = (wr_value[22:0] != 23'd0) ? 3'b100 : 3'b010;
        end else if (wr_value[30:0] == 31'd0) begin
            wr_flags = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_valid) begin
            mem_tag[wr_ptr]   <= wr_tag;
            mem_value[wr_ptr] <= wr_value;
            mem_flags[wr_ptr] <= wr_flags;
        end
    end

    // Next head: bypass the write when the FIFO would otherwise drain.
    always_comb begin
        fcount_nxt     = fcount + CW'(wr_valid) - CW'(pop);
        fremain        = fcount - CW'(pop);
        cnt_nxt        = cnt + CW'(accept) - CW'(pop);
        rd_ptr_nxt     = rd_ptr + PW'(pop);
        head_req_nxt   = (fcount_nxt != '0);
        head_tag_nxt   = '0;
        head_value_nxt = '0;
        head_flags_nxt = '0;
        if (head_req_nxt) begin
            if (fremain == '0) begin
                head_tag_nxt   = wr_tag;
                head_value_nxt = wr_value;
                head_flags_nxt = wr_flags;
            end else begin
                head_tag_nxt   = mem_tag[rd_ptr_nxt];
                head_value_nxt = mem_value[rd_ptr_nxt];
                head_flags_nxt = mem_flags[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_tag      <= '0;
            mul_x1      <= '0;
            mul_x2      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fcount      <= '0;
            cnt         <= '0;
            issue_ready <= 1'b1;
            busy        <= 1'b0;
            cdb_req     <= 1'b0;
            cdb_tag     <= '0;
            cdb_value   <= '0;
            cdb_flags   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_tag <= issue_tag;
                mul_x1 <= issue_a;
                mul_x2 <= issue_b;
            end
            if (wr_valid) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr      <= rd_ptr_nxt;
            fcount      <= fcount_nxt;
            cnt         <= cnt_nxt;
            issue_ready <= (cnt_nxt < CW'(DEPTH));
            busy        <= (cnt_nxt != '0);
            cdb_req     <= head_req_nxt;
            cdb_tag     <= head_tag_nxt;
            cdb_value   <= head_value_nxt;
            cdb_flags   <= head_flags_nxt;
        end
    end

    // Credits bound the FIFO occupancy, so a write into a full FIFO is a bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_valid && (fcount == CW'(DEPTH))));

endmodule

// File: tb/tb_fmul_exec_pipe.sv
// Self-checking bench for fmul_exec_pipe: queue-based reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_fmul_exec_pipe;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic [TAG_W-1:0] issue_tag = '0;
    logic [31:0]      issue_a = '0;
    logic [31:0]      issue_b = '0;
    logic [31:0]      mul_x1;
    logic [31:0]      mul_x2;
    logic [31:0]      mul_x3;
    logic             cdb_req;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic [2:0]       cdb_flags;
    logic             cdb_grant = 1'b0;
    logic             busy;

    always #5 clk = ~clk;

    // Stand-in for the combinational fpMult: known vectors, else a fixed scramble.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h411C0000, 32'h3F100000}: return 32'h40AF8000;
            {32'hC0800000, 32'h3E800000}: return 32'hBF800000;
            {32'h00000000, 32'hD20EE979}: return 32'h80000000;
            {32'h7FFFFFFF, 32'h00000000}: return 32'h7FC00000;
            {32'h7F800000, 32'h7F800000}: return 32'h7F800000;
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            default:                      return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    assign mul_x3 = fmul_ref(mul_x1, mul_x2);

    fmul_exec_pipe #(.TAG_W(TAG_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_tag(issue_tag), .issue_a(issue_a), .issue_b(issue_b),
        .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_x3(mul_x3),
        .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_flags(cdb_flags), .cdb_grant(cdb_grant), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // Reference model: each accepted op becomes visible LAT edges later, in order.
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      value;
        int               rdy;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_x1 = '0;
    logic [31:0] m_x2 = '0;
    int          cyc = 0;
    bit          m_pop;
    bit          m_acc;
    bit          check_en = 1'b0;

    function automatic logic [2:0] class_flags(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[30:23];
        m = v[22:0];
        if (e == 8'd255 && m != 23'd0) return 3'b100;
        if (e == 8'd255) return 3'b010;
        if (e == 8'd0 && m == 23'd0) return 3'b001;
        return 3'b000;
    endfunction

    function automatic bit head_ready();
        return (q.size() > 0) && (q[0].rdy <= cyc);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_x1 = '0;
            m_x2 = '0;
            cyc  = 0;
        end else begin
            m_acc = issue_valid && (q.size() < int'(DEPTH));
            m_pop = cdb_grant && head_ready();
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                q.push_back('{issue_tag, fmul_ref(issue_a, issue_b), cyc + int'(LAT)});
                m_x1 = issue_a;
                m_x2 = issue_b;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic [39:0] exp_cdb;
        if (check_en) begin
            exp_cdb = '0;
            if (head_ready()) exp_cdb = {1'b1, q[0].tag, q[0].value, class_flags(q[0].value)};
            chk("model_cdb", 96'({cdb_req, cdb_tag, cdb_value, cdb_flags}), 96'(exp_cdb));
            chk("model_ready_busy", 96'({issue_ready, busy}),
                96'({q.size() < int'(DEPTH), q.size() != 0}));
            chk("model_mul_x", 96'({mul_x1, mul_x2}), 96'({m_x1, m_x2}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string name, input logic [TAG_W-1:0] tag,
                               input logic [31:0] value, input logic [2:0] flags,
                               input int exp_lat);
        int n;
        n = 0;
        while (!cdb_req && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_req"}, 96'(cdb_req), 96'(1));
        if (exp_lat >= 0) chk({name, "_lat"}, 96'(n), 96'(exp_lat));
        chk({name, "_fields"}, 96'({cdb_tag, cdb_value, cdb_flags}), 96'({tag, value, flags}));
    endtask

    task automatic run_batch(input int base, input int n, input int hold);
        cdb_grant = (hold == 0);
        fork
            begin : issuer
                for (int i = 0; i < n; i++) begin
                    int g;
                    bit rdy;
                    issue_valid = 1'b1;
                    issue_tag   = TAG_W'(base + i);
                    issue_a     = 32'h3F800000 + 32'(i);
                    issue_b     = 32'h40000000 ^ 32'(i << 4);
                    g = 0;
                    do begin
                        rdy = issue_ready;
                        tick();
                        g++;
                    end while (!rdy && g < 100);
                end
                issue_valid = 1'b0;
            end
            begin : collector
                int got[$];
                int g;
                if (hold > 0) begin
                    repeat (hold) tick();
                    chk("bp_ready_low", 96'(issue_ready), 96'(0));
                    chk("bp_busy", 96'(busy), 96'(1));
                    cdb_grant = 1'b1;
                end
                g = 0;
                while (got.size() < n && g < 300) begin
                    if (cdb_req && cdb_grant) got.push_back(int'(cdb_tag));
                    tick();
                    g++;
                end
                chk("batch_count", 96'(got.size()), 96'(n));
                for (int i = 0; i < got.size(); i++) chk("batch_order", 96'(got[i]), 96'(base + i));
                cdb_grant = 1'b0;
            end
        join
    endtask

    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vp [4];
    logic [2:0]  vf [4];

    initial begin
        va[0] = 32'hC0800000; vb[0] = 32'h3E800000; vp[0] = 32'hBF800000; vf[0] = 3'b000;
        va[1] = 32'h00000000; vb[1] = 32'hD20EE979; vp[1] = 32'h80000000; vf[1] = 3'b001;
        va[2] = 32'h7FFFFFFF; vb[2] = 32'h00000000; vp[2] = 32'h7FC00000; vf[2] = 3'b100;
        va[3] = 32'h7F800000; vb[3] = 32'h7F800000; vp[3] = 32'h7F800000; vf[3] = 3'b010;

        tick();
        chk("reset_outputs",
            96'({issue_ready, cdb_req, busy, cdb_tag, cdb_value, cdb_flags, mul_x1, mul_x2}),
            96'({1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 3'b000, 32'h0, 32'h0}));
        tick();
        rst = 1'b0;
        check_en = 1'b1;

        // Single op, latency and pop
        issue_valid = 1'b1;
        issue_tag = 4'd5; issue_a = 32'h411C0000; issue_b = 32'h3F100000;
        tick();
        issue_valid = 1'b0;
        wait_result("single", 4'd5, 32'h40AF8000, 3'b000, int'(LAT) - 1);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        chk("single_drained", 96'({cdb_req, busy}), 96'(0));

        // Signs, zero and specials, drained back-to-back
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_tag = TAG_W'(i + 1); issue_a = va[i]; issue_b = vb[i];
            tick();
        end
        issue_valid = 1'b0;
        cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_result("vec", TAG_W'(i + 1), vp[i], vf[i], 0);
            tick();
        end
        cdb_grant = 1'b0;
        repeat (2) tick();

        // Backpressure: 6 ops against 4 credits, then full-boundary accept+pop
        run_batch(0, 6, 8);
        repeat (2) tick();
        // Streaming with grant held, including grants while empty
        run_batch(8, 8, 0);
        repeat (2) tick();

        // Reset with two ops in the pipe and one in the FIFO
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1;
            issue_tag = TAG_W'(i + 1); issue_a = va[i]; issue_b = vb[i];
            tick();
        end
        issue_valid = 1'b0;
        chk("pre_reset_state", 96'({cdb_req, busy, issue_ready}), 96'({1'b1, 1'b1, 1'b1}));
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            96'({issue_ready, cdb_req, busy, cdb_tag, cdb_value, cdb_flags, mul_x1, mul_x2}),
            96'({1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 3'b000, 32'h0, 32'h0}));
        tick();
        rst = 1'b0;
        issue_valid = 1'b1;
        issue_tag = 4'd9; issue_a = 32'h40000000; issue_b = 32'h40400000;
        cdb_grant = 1'b1;
        tick();
        issue_valid = 1'b0;
        wait_result("post_reset", 4'd9, 32'h40C00000, 3'b000, int'(LAT) - 1);
        tick();
        chk("post_reset_no_stale", 96'({cdb_req, busy}), 96'(0));
        repeat (6) tick();
        cdb_grant = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
